// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared FSM state type and index-width helper for arb_mux.
package arb_mux_pkg;
  typedef enum logic {IDLE, LOCKED} state_e;
  function automatic int clog2_min1(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational arbiter; round robin from ptr_i when ARB_MUX_ROUND_ROBIN_EN, else lowest index wins.
module arb_pick
  import arb_mux_pkg::*;
#(
  parameter int channels = 4,
  parameter int sel_width = clog2_min1(channels)
) (
  input  logic [channels-1:0]  req_i,
  input  logic [sel_width-1:0] ptr_i,
  output logic [channels-1:0]  gnt_o,
  output logic [sel_width-1:0] idx_o
);
`ifdef ARB_MUX_ROUND_ROBIN_EN
  always_comb begin
    idx_o = '0;
    for (int k = channels - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % channels]) idx_o = sel_width'((int'(ptr_i) + k) % channels);
    gnt_o = |req_i ? channels'(1) << idx_o : '0;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  always_comb begin
    idx_o = '0;
    for (int k = channels - 1; k >= 0; k--)
      if (req_i[k]) idx_o = sel_width'(k);
    gnt_o = |req_i ? channels'(1) << idx_o : '0;
  end
`endif
endmodule

// File: rtl/arb_mux.sv
// arb_mux: N-channel stream mux with packet-level arbitration and registered output.
// ARB_MUX_ROUND_ROBIN_EN selects round-robin arbitration (fixed priority otherwise).
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int width = 32,
  parameter int channels = 4,
  localparam int sel_width = clog2_min1(channels)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [channels*width-1:0] in_data,
  input  logic [channels-1:0]       in_valid,
  input  logic [channels-1:0]       in_last,
  output logic [channels-1:0]       in_ready,
  output logic [width-1:0]          out_data,
  output logic                      out_last,
  output logic [sel_width-1:0]      out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  state_e state_q, state_d;
  logic [sel_width-1:0] grant_q, grant_d, ptr, pick_idx, cur_idx;
  logic [channels-1:0] pick_gnt, sel_oh;
  logic can_load, xfer, beat_last;
  logic [width-1:0] beat_data;
  logic [width-1:0] out_data_q;
  logic out_last_q, out_valid_q;
  logic [sel_width-1:0] out_channel_q;

  arb_pick #(.channels(channels), .sel_width(sel_width)) u_pick (
    .req_i(in_valid),
    .ptr_i(ptr),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );

  assign can_load  = !out_valid_q || out_ready;
  assign cur_idx   = (state_q == LOCKED) ? grant_q : pick_idx;
  assign sel_oh    = (state_q == LOCKED) ? channels'(1) << grant_q : pick_gnt;
  assign xfer      = |(in_valid & in_ready);
  assign beat_data = in_data[int'(cur_idx)*width +: width];
  assign beat_last = in_last[cur_idx];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (xfer) begin
      state_d = beat_last ? IDLE : LOCKED;
      grant_d = cur_idx;
    end
  end

  always_comb in_ready = can_load ? sel_oh : '0;

`ifdef ARB_MUX_ROUND_ROBIN_EN
  logic [sel_width-1:0] ptr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else if (xfer && beat_last) ptr_q <= (int'(cur_idx) == channels - 1) ? '0 : cur_idx + 1'b1;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Payload fields hold after the beat is consumed; only valid clears.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
    end else if (xfer) begin
      out_data_q    <= beat_data;
      out_last_q    <= beat_last;
      out_channel_q <= cur_idx;
      out_valid_q   <= 1'b1;
    end else if (out_ready) begin
      out_valid_q   <= 1'b0;
    end

  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign out_channel = out_channel_q;
  assign out_valid   = out_valid_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed self-checking bench for arb_mux.
module tb_arb_mux;
  localparam int W = 32;
  localparam int C = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [C*W-1:0] in_data;
  logic [C-1:0] in_valid, in_last, in_ready;
  logic [W-1:0] out_data;
  logic out_last, out_valid, out_ready;
  logic [1:0] out_channel;
  int errors = 0;
  int checks = 0;
  logic [35:0] exp_o;
  logic [C-1:0] exp_r;
  wire [35:0] obs = {out_valid, out_last, out_channel, out_data};

  always #5 clk = ~clk;

  arb_mux #(.width(W), .channels(C)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_channel(out_channel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle_in;
    in_valid = '0;
    in_last = '0;
    in_data = '0;
  endtask

  task set_ch(input int i, input logic v, input logic l, input logic [W-1:0] d);
    in_valid[i] = v;
    in_last[i] = l;
    in_data[i*W +: W] = d;
  endtask

  task do_reset;
    idle_in();
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task test_reset;
    do_reset();
    exp_o = '0;
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL reset_out got=%h exp=%h", obs, exp_o); end
    checks++;
    if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    set_ch(2, 1'b1, 1'b1, 32'hA5);
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", in_ready); end
    tick();
    exp_o = {1'b1, 1'b1, 2'd2, 32'hA5};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL single_out got=%h exp=%h", obs, exp_o); end
    idle_in();
    tick();
    exp_o = {1'b0, 1'b1, 2'd2, 32'hA5};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL single_drain got=%h exp=%h", obs, exp_o); end
  endtask

  task test_lock;
    set_ch(1, 1'b1, 1'b0, 32'h11);
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_b0_ready got=%b exp=0010", in_ready); end
    tick();
    exp_o = {1'b1, 1'b0, 2'd1, 32'h11};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL lock_b0_out got=%h exp=%h", obs, exp_o); end
    set_ch(0, 1'b1, 1'b1, 32'h100);
    for (int b = 1; b < 3; b++) begin
      set_ch(1, 1'b1, b == 2, 32'h11 + b);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_b%0d_ready got=%b exp=0010", b, in_ready); end
      tick();
      exp_o = {1'b1, b == 2, 2'd1, 32'h11 + b};
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL lock_b%0d_out got=%h exp=%h", b, obs, exp_o); end
    end
    set_ch(1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL lock_next_ready got=%b exp=0001", in_ready); end
    tick();
    exp_o = {1'b1, 1'b1, 2'd0, 32'h100};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL lock_next_out got=%h exp=%h", obs, exp_o); end
    idle_in();
    tick();
  endtask

  task test_priority;
    int e;
    do_reset();
    for (int i = 0; i < C; i++) set_ch(i, 1'b1, 1'b1, 32'hC0 + i);
    for (int k = 0; k < 5; k++) begin
`ifdef ARB_MUX_ROUND_ROBIN_EN
      e = k % C;
`else
      e = 0;
`endif
      exp_r = 4'b0001 << e;
      #1;
      checks++;
      if (in_ready !== exp_r) begin errors++; $display("FAIL prio_%0d_ready got=%b exp=%b", k, in_ready, exp_r); end
      tick();
      exp_o = {1'b1, 1'b1, e[1:0], 32'hC0 + e};
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL prio_%0d_out got=%h exp=%h", k, obs, exp_o); end
    end
    idle_in();
    tick();
  endtask

  task test_backpressure;
    do_reset();
    set_ch(2, 1'b1, 1'b0, 32'h20);
    #1;
    tick();
    exp_o = {1'b1, 1'b0, 2'd2, 32'h20};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL bp_b0_out got=%h exp=%h", obs, exp_o); end
    for (int b = 1; b < 4; b++) begin
      set_ch(2, 1'b1, b == 3, 32'h20 + b);
      if (b == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          checks++;
          if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall%0d_ready got=%b exp=0000", s, in_ready); end
          tick();
          checks++;
          if (obs !== exp_o) begin errors++; $display("FAIL bp_stall%0d_out got=%h exp=%h", s, obs, exp_o); end
        end
        out_ready = 1'b1;
      end
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_b%0d_ready got=%b exp=0100", b, in_ready); end
      tick();
      exp_o = {1'b1, b == 3, 2'd2, 32'h20 + b};
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL bp_b%0d_out got=%h exp=%h", b, obs, exp_o); end
    end
    idle_in();
    tick();
    exp_o = {1'b0, 1'b1, 2'd2, 32'h23};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL bp_drain got=%h exp=%h", obs, exp_o); end
  endtask

  task test_drop;
    do_reset();
    set_ch(0, 1'b1, 1'b0, 32'h30);
    #1;
    tick();
    set_ch(0, 1'b0, 1'b0, 32'h0);
    set_ch(3, 1'b1, 1'b1, 32'h33);
    exp_o = {1'b0, 1'b0, 2'd0, 32'h30};
    for (int s = 0; s < 2; s++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin errors++; $display("FAIL drop_gap%0d_ready got=%b exp=0001", s, in_ready); end
      tick();
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL drop_gap%0d_out got=%h exp=%h", s, obs, exp_o); end
    end
    for (int b = 1; b < 3; b++) begin
      set_ch(0, 1'b1, b == 2, 32'h30 + b);
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin errors++; $display("FAIL drop_b%0d_ready got=%b exp=0001", b, in_ready); end
      tick();
      exp_o = {1'b1, b == 2, 2'd0, 32'h30 + b};
      checks++;
      if (obs !== exp_o) begin errors++; $display("FAIL drop_b%0d_out got=%h exp=%h", b, obs, exp_o); end
    end
    set_ch(0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin errors++; $display("FAIL drop_ch3_ready got=%b exp=1000", in_ready); end
    tick();
    exp_o = {1'b1, 1'b1, 2'd3, 32'h33};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL drop_ch3_out got=%h exp=%h", obs, exp_o); end
    idle_in();
    tick();
  endtask

  task test_reset_mid;
    do_reset();
    set_ch(2, 1'b1, 1'b1, 32'h40);
    #1;
    tick();
    set_ch(2, 1'b0, 1'b0, 32'h0);
    set_ch(1, 1'b1, 1'b0, 32'h41);
    #1;
    tick();
    exp_o = {1'b1, 1'b0, 2'd1, 32'h41};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL rmid_locked got=%h exp=%h", obs, exp_o); end
    #2;
    reset = 1'b1;
    #1;
    exp_o = '0;
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL rmid_async got=%h exp=%h", obs, exp_o); end
    tick();
    reset = 1'b0;
    idle_in();
    set_ch(0, 1'b1, 1'b1, 32'h50);
    set_ch(3, 1'b1, 1'b1, 32'h53);
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL rmid_rearb_ready got=%b exp=0001", in_ready); end
    tick();
    exp_o = {1'b1, 1'b1, 2'd0, 32'h50};
    checks++;
    if (obs !== exp_o) begin errors++; $display("FAIL rmid_rearb_out got=%h exp=%h", obs, exp_o); end
    idle_in();
    tick();
  endtask

  initial begin
    idle_in();
    out_ready = 1'b1;
    test_reset();
    test_lock();
    test_priority();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
